// File: rtl/checkout_pkg.sv
// Shared types and constants for the checkout station tally.
// State encoding, count width and blank-segment pattern.
package checkout_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HOLD,
        ALARM
    } state_t;

    localparam int COUNT_W = 8;
    localparam logic [COUNT_W-1:0] COUNT_MAX = 8'hFF;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [COUNT_W-1:0] sat_inc(
        input logic [COUNT_W-1:0] v
    );
        return (v == COUNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/seg7_hex.sv
// Hex nibble to active-low 7-segment pattern (gfedcba).
// Purely combinational.
module seg7_hex (
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    // nibble to segment lookup
    always_comb begin
        o_seg = 7'b1111111;
        unique case (i_nib)
            4'h0: o_seg = 7'b1000000;
            4'h1: o_seg = 7'b1111001;
            4'h2: o_seg = 7'b0100100;
            4'h3: o_seg = 7'b0110000;
            4'h4: o_seg = 7'b0011001;
            4'h5: o_seg = 7'b0010010;
            4'h6: o_seg = 7'b0000010;
            4'h7: o_seg = 7'b1111000;
            4'h8: o_seg = 7'b0000000;
            4'h9: o_seg = 7'b0010000;
            4'hA: o_seg = 7'b0001000;
            4'hB: o_seg = 7'b0000011;
            4'hC: o_seg = 7'b1000110;
            4'hD: o_seg = 7'b0100001;
            4'hE: o_seg = 7'b0000110;
            4'hF: o_seg = 7'b0001110;
            default: o_seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/checkout_tally.sv
// Debounced scan commit, saturating tallies and stolen-item alarm.
// Define CHECKOUT_HEX_EN to drive the HEX displays from the counts.
module checkout_tally
    import checkout_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               scan_n,
    input  logic               clear,
    input  logic [2:0]         upc,
    input  logic               marked,
    input  logic               discounted,
    input  logic               stolen,
    output logic [COUNT_W-1:0] item_count,
    output logic [COUNT_W-1:0] disc_count,
    output logic [2:0]         last_upc,
    output logic               item_pulse,
    output logic               alarm,
    output logic [6:0]         hex0,
    output logic [6:0]         hex1,
    output logic [6:0]         hex2,
    output logic [6:0]         hex3
);

    localparam logic [16:0] DB_LAST = 17'(DEBOUNCE_CYCLES);

    logic               r_sync1;
    logic               r_sync2;
    logic [15:0]        r_cnt;
    state_t             r_state;
    logic [COUNT_W-1:0] r_items;
    logic [COUNT_W-1:0] r_discs;
    logic [2:0]         r_last;
    logic               r_pulse;
    logic               r_alarm;

    state_t             w_next;
    logic               w_commit;
    logic               w_cnt_clr;
    logic               w_cnt_inc;
    logic               w_unused;

    // marked only feeds the upstream classifier
    assign w_unused = marked;

    // two-flop synchroniser, released level is high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= scan_n;
            r_sync2 <= r_sync1;
        end
    end

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state and commit decision
    always_comb begin
        w_next    = r_state;
        w_commit  = 1'b0;
        w_cnt_clr = 1'b0;
        w_cnt_inc = 1'b0;
        if (clear) begin
            w_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (!r_sync2) begin
                        w_cnt_clr = 1'b1;
                        w_next    = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (r_sync2) begin
                        w_next = IDLE;
                    end else begin
                        w_cnt_inc = 1'b1;
                        if (({1'b0, r_cnt} + 17'd1) == DB_LAST) begin
                            w_commit = 1'b1;
                            w_next   = stolen ? ALARM : HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (r_sync2) begin
                        w_next = IDLE;
                    end
                end
                ALARM: begin
                    w_next = ALARM;
                end
                default: begin
                    w_next = IDLE;
                end
            endcase
        end
    end

    // debounce stability counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // tallies, last item and commit strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_items <= '0;
            r_discs <= '0;
            r_last  <= '0;
            r_pulse <= 1'b0;
        end else if (clear) begin
            r_items <= '0;
            r_discs <= '0;
            r_last  <= '0;
            r_pulse <= 1'b0;
        end else if (w_commit && !stolen) begin
            r_items <= sat_inc(r_items);
            if (discounted) begin
                r_discs <= sat_inc(r_discs);
            end
            r_last  <= upc;
            r_pulse <= 1'b1;
        end else begin
            r_pulse <= 1'b0;
        end
    end

    // registered alarm tracks entry into the lockout state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_alarm <= 1'b0;
        end else begin
            r_alarm <= (w_next == ALARM);
        end
    end

    assign item_count = r_items;
    assign disc_count = r_discs;
    assign last_upc   = r_last;
    assign item_pulse = r_pulse;
    assign alarm      = r_alarm;

`ifdef CHECKOUT_HEX_EN
    seg7_hex u_hex0 (.i_nib(r_items[3:0]), .o_seg(hex0));
    seg7_hex u_hex1 (.i_nib(r_items[7:4]), .o_seg(hex1));
    seg7_hex u_hex2 (.i_nib(r_discs[3:0]), .o_seg(hex2));
    seg7_hex u_hex3 (.i_nib(r_discs[7:4]), .o_seg(hex3));
`else
    assign hex0 = SEG_BLANK;
    assign hex1 = SEG_BLANK;
    assign hex2 = SEG_BLANK;
    assign hex3 = SEG_BLANK;
`endif

endmodule

// File: doc/checkout_tally.md
# checkout_tally

Downstream consumer of the combinational item classifier on the DE-1 SoC checkout station. It turns a raw scan push-button into one debounced commit per press, latches the classifier's discounted/stolen verdict for the scanned item, and keeps saturating item and discount totals. A stolen verdict locks the station into an alarm state until a clerk clears it. Totals can optionally be driven to the HEX displays.

## Interface
- DEBOUNCE_CYCLES, default 16: consecutive cycles the synchronised button must be stable low before a commit; legal range 1..65535.
- clk  input  1  system clock (CLOCK_50 at top level).
- reset_n  input  1  asynchronous, active-low reset.
- scan_n  input  1  raw scan button (KEY), active-low, asynchronous to clk, bouncy.
- clear  input  1  synchronous clerk clear, active-high.
- upc  input  3  item code from switches, quasi-static during a press.
- marked  input  1  secret-mark switch.
- discounted  input  1  classifier discount verdict for the current upc/marked.
- stolen  input  1  classifier stolen verdict for the current upc/marked.
- item_count  output  8  items committed, saturating.
- disc_count  output  8  discounted items committed, saturating.
- last_upc  output  3  upc of the most recent commit.
- item_pulse  output  1  one-cycle strobe on each non-stolen commit.
- alarm  output  1  high while in ALARM.
- hex0, hex1, hex2, hex3  output  7  active-low segments: item_count low/high nibble, then disc_count low/high nibble.

## Operation
- scan_n passes through a 2-flop synchroniser (s2). The FSM uses only s2.
- The FSM has four states. Its reset state is IDLE.
  - IDLE: if s2=0, clear the debounce counter and go to DEBOUNCE.
  - DEBOUNCE: if s2=1, go to IDLE with no commit. Otherwise increment the counter. When the counter reaches DEBOUNCE_CYCLES, commit:
    - If stolen=1, go to ALARM. Counts, last_upc and item_pulse are unchanged.
    - Otherwise, increment item_count and increment disc_count if discounted=1. Both saturate at 255. Load last_upc and pulse item_pulse. Go to HOLD.
  - HOLD: wait for s2=1, then go to IDLE. There is exactly one commit per press, however long the button is held.
  - ALARM: alarm=1 and all presses are ignored. Only clear exits, to IDLE.
- clear in any state:
  - Zeroes item_count and disc_count.
  - Zeroes last_upc.
  - Forces IDLE.
  - clear wins over a same-cycle commit: no pulse, counts stay 0.
- upc, marked, discounted and stolen are sampled only on the commit edge.
- Reset values:
  - item_count=0, disc_count=0, last_upc=0.
  - item_pulse=0, alarm=0, state IDLE.
  - Synchroniser flops=1 (released).
  - Debounce counter=0.
  - hex outputs per Configuration.

## Timing
- scan_n falling before edge 0 and held low: s2 is low from edge 2. The commit edge is edge 2+DEBOUNCE_CYCLES. Counts, last_upc and item_pulse are visible right after that edge.
- item_pulse is high for exactly one cycle per commit. alarm rises on the commit edge of a stolen item.
- A release shorter than the synchroniser window merges into the current press. A new press requires s2=1 to be seen in HOLD.
- clear takes effect on the next edge. alarm falls one cycle after clear is sampled.
- Reset mid-DEBOUNCE or mid-HOLD returns to IDLE immediately with no commit. A button still held after reset release is treated as a new press.
- All outputs are registered, except the hex decode, which is combinational from the registered counts.

## Configuration
- CHECKOUT_HEX_EN defined: four seg7_hex instances drive hex0..hex3 from the counts. The hex digit 0 is 7'b1000000.
- Not defined: hex0..hex3 are tied to 7'b1111111 (blank), and no decoders are built.

## Structure
- checkout_pkg holds:
  - the state enum (IDLE, DEBOUNCE, HOLD, ALARM);
  - COUNT_W=8 and COUNT_MAX=8'hFF;
  - SEG_BLANK=7'b1111111.
- Sub-module seg7_hex: a 4-bit hex nibble to 7 active-low segments, purely combinational.
- The synchroniser, counter, FSM and tally registers live in checkout_tally.

## Test plan
Run with DEBOUNCE_CYCLES=4.
- Reset: hold reset_n low, release. Required: item_count=0, disc_count=0, alarm=0, item_pulse=0. With CHECKOUT_HEX_EN, hex0..3=7'b1000000; without it, 7'b1111111.
- Clean press, discounted item: upc=3'b110, discounted=1, stolen=0, scan_n low 12 cycles. Required: item_pulse high exactly at edge 6 after the fall; then item_count=1, disc_count=1, last_upc=3'b110.
- Bounce rejection: scan_n low 3 cycles, high 2, low 3, high. Required: no item_pulse, counts unchanged.
- Stolen lockout: stolen=1, press. Required: alarm=1 at edge 6, counts unchanged, and a further press gives no pulse. Assert clear for 1 cycle: alarm=0 and counts=0 on the next cycle.
- Saturation: 260 non-stolen discounted presses. Required: item_count=255, disc_count=255, and item_pulse still pulses on every press.
- Clear/commit collision and reset mid-press: clear on the commit edge gives no pulse and counts 0. reset_n low during DEBOUNCE gives no commit, and after release a held button commits once at edge 6.
